// File: rtl/scariv_csr_resp_unit.sv
// Machine-mode CSR responder for the CSU pipe: mstatus subset, trap CSRs, mcycle/minstret.
// Latency: reads and error flags are combinational in the request cycle; legal writes commit on the next edge.
// Backpressure: none; every request is answered in its own cycle, and illegal writes are flagged and dropped.
module scariv_csr_resp_unit #(
  parameter int          XLEN_W    = 64,
  parameter int          CMT_CNT_W = 3,
  parameter int unsigned HART_ID   = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  // read port
  input  logic                 read_if_valid,
  input  logic [11:0]          read_if_addr,
  output logic [XLEN_W-1:0]    read_if_data,
  output logic                 read_if_resp_error,
  // write port
  input  logic                 write_if_valid,
  input  logic [11:0]          write_if_addr,
  input  logic [XLEN_W-1:0]    write_if_data,
  output logic                 write_if_resp_error,
  // commit side
  input  logic [CMT_CNT_W-1:0] i_retire_cnt,
  input  logic                 i_mret,
  output logic [XLEN_W-1:0]    o_mstatus,
  output logic [1:0]           o_status_priv
);

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_M = 2'b11;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MCNTINH  = 12'h320;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_CYCLE    = 12'hC00;
  localparam logic [11:0] A_INSTRET  = 12'hC02;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  // MXL=2 (RV64) in the top two bits, extension letters A C D F I M S U below.
  localparam logic [XLEN_W-1:0] MISA_VAL = {2'b10, {(XLEN_W-28){1'b0}}, 26'h014112D};

  // architectural state
  logic              mie_q, mie_d;
  logic              mpie_q, mpie_d;
  logic [1:0]        mpp_q, mpp_d;
  logic [1:0]        fs_q, fs_d;
  logic              tsr_q, tsr_d;
  logic [1:0]        priv_q, priv_d;
  logic [XLEN_W-1:0] mtvec_q, mtvec_d;
  logic [XLEN_W-1:0] mscratch_q, mscratch_d;
  logic [XLEN_W-1:0] mepc_q, mepc_d;
  logic [XLEN_W-1:0] mcause_q, mcause_d;
  logic [XLEN_W-1:0] mtval_q, mtval_d;
  logic              cy_q, cy_d;
  logic              ir_q, ir_d;
  logic [XLEN_W-1:0] mcycle_q, mcycle_d;
  logic [XLEN_W-1:0] minstret_q, minstret_d;

  logic [XLEN_W-1:0] mstatus_val;
  logic              rd_err;
  logic              wr_err;
  logic              wr_ok;

  function automatic logic addr_impl(input logic [11:0] a);
    case (a)
      A_MSTATUS, A_MISA, A_MTVEC, A_MCNTINH, A_MSCRATCH, A_MEPC, A_MCAUSE, A_MTVAL,
      A_MCYCLE, A_MINSTRET, A_CYCLE, A_INSTRET, A_MHARTID: addr_impl = 1'b1;
      default:                                             addr_impl = 1'b0;
    endcase
  endfunction

  // Access fault: unimplemented address, insufficient privilege, or cycle/instret alias outside M-mode.
  function automatic logic access_err(input logic [11:0] a, input logic [1:0] p);
    access_err = !addr_impl(a) || (a[9:8] > p) ||
                 (((a == A_CYCLE) || (a == A_INSTRET)) && (p != PRIV_M));
  endfunction

  // Pack the implemented mstatus fields; everything else reads as zero.
  always_comb begin
    mstatus_val       = '0;
    mstatus_val[3]    = mie_q;
    mstatus_val[7]    = mpie_q;
    mstatus_val[12:11] = mpp_q;
    mstatus_val[14:13] = fs_q;
    mstatus_val[22]   = tsr_q;
  end

  assign o_mstatus     = mstatus_val;
  assign o_status_priv = priv_q;

  // Combinational read response; erroring or idle reads return zero.
  always_comb begin
    read_if_data       = '0;
    read_if_resp_error = 1'b0;
    rd_err             = access_err(read_if_addr, priv_q);
    if (read_if_valid) begin
      read_if_resp_error = rd_err;
      if (!rd_err) begin
        case (read_if_addr)
          A_MSTATUS:             read_if_data = mstatus_val;
          A_MISA:                read_if_data = MISA_VAL;
          A_MTVEC:               read_if_data = mtvec_q;
          A_MCNTINH:             read_if_data = {{(XLEN_W-3){1'b0}}, ir_q, 1'b0, cy_q};
          A_MSCRATCH:            read_if_data = mscratch_q;
          A_MEPC:                read_if_data = mepc_q;
          A_MCAUSE:              read_if_data = mcause_q;
          A_MTVAL:               read_if_data = mtval_q;
          A_MCYCLE, A_CYCLE:     read_if_data = mcycle_q;
          A_MINSTRET, A_INSTRET: read_if_data = minstret_q;
          A_MHARTID:             read_if_data = XLEN_W'(HART_ID);
          default:               read_if_data = '0;
        endcase
      end
    end
  end

  // Combinational write response; the 0xC00-0xFFF range is read-only.
  always_comb begin
    wr_err              = access_err(write_if_addr, priv_q) || (write_if_addr[11:10] == 2'b11);
    write_if_resp_error = write_if_valid && wr_err;
    wr_ok               = write_if_valid && !wr_err;
  end

  // Next-state: counter increments, then legal writes (which override increments), then MRET.
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mpp_d      = mpp_q;
    fs_d       = fs_q;
    tsr_d      = tsr_q;
    priv_d     = priv_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    cy_d       = cy_q;
    ir_d       = ir_q;
    mcycle_d   = cy_q ? mcycle_q : (mcycle_q + 1'b1);
    minstret_d = ir_q ? minstret_q : (minstret_q + XLEN_W'(i_retire_cnt));

    if (wr_ok) begin
      case (write_if_addr)
        A_MSTATUS: begin
          // MRET in the same cycle owns mstatus; the write is silently dropped.
          if (!i_mret) begin
            mie_d  = write_if_data[3];
            mpie_d = write_if_data[7];
            mpp_d  = (write_if_data[12:11] == 2'b10) ? PRIV_U : write_if_data[12:11];
            fs_d   = write_if_data[14:13];
            tsr_d  = write_if_data[22];
          end
        end
        A_MTVEC:    mtvec_d    = write_if_data;
        A_MCNTINH: begin
          cy_d = write_if_data[0];
          ir_d = write_if_data[2];
        end
        A_MSCRATCH: mscratch_d = write_if_data;
        A_MEPC:     mepc_d     = {write_if_data[XLEN_W-1:1], 1'b0};
        A_MCAUSE:   mcause_d   = write_if_data;
        A_MTVAL:    mtval_d    = write_if_data;
        A_MCYCLE:   mcycle_d   = write_if_data;
        A_MINSTRET: minstret_d = write_if_data;
        default: ;
      endcase
    end

    if (i_mret) begin
      priv_d = mpp_q;
      mie_d  = mpie_q;
      mpie_d = 1'b1;
      mpp_d  = PRIV_U;
    end
  end

  // State registers with asynchronous reset to machine mode and all-zero CSRs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mpp_q      <= 2'b00;
      fs_q       <= 2'b00;
      tsr_q      <= 1'b0;
      priv_q     <= PRIV_M;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      cy_q       <= 1'b0;
      ir_q       <= 1'b0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mpp_q      <= mpp_d;
      fs_q       <= fs_d;
      tsr_q      <= tsr_d;
      priv_q     <= priv_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      cy_q       <= cy_d;
      ir_q       <= ir_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

endmodule
